timer_regs_core: RTL and testbench



---
 rtl/timer_regs_core_pkg.sv | 37 +++
 rtl/timer_regs_core_tick.sv | 46 ++++
 rtl/timer_regs_core.sv | 179 +++++++++++++++++
 tb/tb_timer_regs_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_regs_core_pkg.sv
// timer_regs_core_pkg
//   Shared register map, bit positions and type definitions for the
//   timer_regs_core peripheral and its tick generator.
//   Optional feature macro: TIMER_PRESCALER_EN (adds the PRESCALE register).
package timer_regs_core_pkg;

   // Register byte addresses
   localparam int unsigned P_ADDR_CONTROL  = 32'h00;
   localparam int unsigned P_ADDR_LOAD     = 32'h04;
   localparam int unsigned P_ADDR_STATUS   = 32'h08;
   localparam int unsigned P_ADDR_COUNT    = 32'h0C;
   localparam int unsigned P_ADDR_PRESCALE = 32'h10;

   // CONTROL bit positions
   localparam int unsigned P_BIT_START      = 0;
   localparam int unsigned P_BIT_RELOAD_EN  = 1;
   localparam int unsigned P_BIT_CLR_STATUS = 2;

   // STATUS bit positions
   localparam int unsigned P_BIT_EXPIRED = 0;

   // Width of the PRESCALE register and prescaler counter
   localparam int unsigned P_PRESCALE_WIDTH = 16;

   // Bus access kind
   typedef enum logic {
      KIND_WRITE = 1'b0,
      KIND_READ  = 1'b1
   } kind_s;

   // Counter FSM: IDLE while START=0, RUN while counting
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/timer_regs_core_tick.sv
// timer_tick_gen
//   Produces the count-enable tick for the timer down-counter.
//   With TIMER_PRESCALER_EN defined, tick asserts once every prescale+1
//   clocks while run is high; the divider restarts on restart.
//   Without the macro, tick is constant 1 (gated by the FSM in the top).
// Ports:
//   clk, rst  : core clock, asynchronous active-high reset
//   run       : counter FSM is in RUN
//   restart   : START 0->1 write accepted this cycle
//   prescale  : divider value (tick period = prescale+1 clocks)
//   tick      : count-enable
module timer_tick_gen
   import timer_regs_core_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run,
   input  logic                        restart,
   input  logic [P_PRESCALE_WIDTH-1:0] prescale,
   output logic                        tick
);

`ifdef TIMER_PRESCALER_EN
   logic [P_PRESCALE_WIDTH-1:0] pcnt;

   // >= rather than == so a PRESCALE lowered mid-run cannot make the
   // divider wrap through its full range.
   assign tick = run && (pcnt >= prescale);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (restart) begin
         pcnt <= '0;
      end else if (run) begin
         if (pcnt >= prescale) pcnt <= '0;
         else                  pcnt <= pcnt + 1'b1;
      end
   end
`else
   logic unused_tick_inputs;
   assign unused_tick_inputs = ^{clk, rst, run, restart, prescale};
   assign tick = 1'b1;
`endif

endmodule

// File: rtl/timer_regs_core.sv
// timer_regs_core
//   Memory-mapped timer: single-beat register decode plus a 32-bit
//   down-counter with optional auto-reload and a sticky expiry flag.
//   Map: CONTROL 0x00 (RW), LOAD 0x04 (RW), STATUS 0x08 (RO),
//        COUNT 0x0C (RO), PRESCALE 0x10 (RW, only with TIMER_PRESCALER_EN).
// Ports:
//   clk, rst : core clock, asynchronous active-high reset
//   req      : access request (accepted whenever ready)
//   kind     : 0 = WRITE, 1 = READ
//   addr     : byte address
//   wdata    : write data
//   ready    : accepts req (low only during reset)
//   rdata    : read data, valid with rvalid, held otherwise
//   rvalid   : one-cycle read response strobe
//   err      : one-cycle strobe for access to an unmapped address
//   irq      : level, mirrors STATUS.expired
// Optional feature macro: TIMER_PRESCALER_EN
module timer_regs_core
   import timer_regs_core_pkg::*;
#(
   parameter int unsigned P_ADDR_WIDTH = 8,
   parameter int unsigned P_DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   input  logic                    kind,
   input  logic [P_ADDR_WIDTH-1:0] addr,
   input  logic [P_DATA_WIDTH-1:0] wdata,
   output logic                    ready,
   output logic [P_DATA_WIDTH-1:0] rdata,
   output logic                    rvalid,
   output logic                    err,
   output logic                    irq
);

   state_e                      state, state_n;
   logic                        reload_en, reload_en_n;
   logic                        expired, expired_n;
   logic [P_DATA_WIDTH-1:0]     load_q, load_n;
   logic [P_DATA_WIDTH-1:0]     count, count_n;
   logic [P_DATA_WIDTH-1:0]     rd_next;
   logic [P_PRESCALE_WIDTH-1:0] prescale;
`ifdef TIMER_PRESCALER_EN
   logic [P_PRESCALE_WIDTH-1:0] prescale_n;
`endif

   logic accept, is_wr, is_rd, mapped, restart, tick;
   logic sel_control, sel_load, sel_status, sel_count, sel_prescale;

   assign ready  = ~rst;
   assign irq    = expired;
   assign accept = req && ready;
   assign is_wr  = accept && (kind_s'(kind) == KIND_WRITE);
   assign is_rd  = accept && (kind_s'(kind) == KIND_READ);

   // Address decode
   assign sel_control = (addr == P_ADDR_WIDTH'(P_ADDR_CONTROL));
   assign sel_load    = (addr == P_ADDR_WIDTH'(P_ADDR_LOAD));
   assign sel_status  = (addr == P_ADDR_WIDTH'(P_ADDR_STATUS));
   assign sel_count   = (addr == P_ADDR_WIDTH'(P_ADDR_COUNT));
`ifdef TIMER_PRESCALER_EN
   assign sel_prescale = (addr == P_ADDR_WIDTH'(P_ADDR_PRESCALE));
`else
   assign sel_prescale = 1'b0;
   assign prescale     = '0;
`endif
   assign mapped = sel_control | sel_load | sel_status | sel_count | sel_prescale;

   assign restart = is_wr && sel_control && wdata[P_BIT_START] && (state == ST_IDLE);

   timer_tick_gen u_tick (
      .clk      (clk),
      .rst      (rst),
      .run      (state == ST_RUN),
      .restart  (restart),
      .prescale (prescale),
      .tick     (tick)
   );

   // Next-state: register writes first, then the counter tick.
   // CLR_STATUS is applied before the expiry so a coincident expiry wins.
   always_comb begin
      state_n     = state;
      reload_en_n = reload_en;
      expired_n   = expired;
      load_n      = load_q;
      count_n     = count;
`ifdef TIMER_PRESCALER_EN
      prescale_n  = prescale;
`endif

      if (is_wr) begin
         if (sel_control) begin
            reload_en_n = wdata[P_BIT_RELOAD_EN];
            if (wdata[P_BIT_CLR_STATUS]) expired_n = 1'b0;
            if (wdata[P_BIT_START]) begin
               if (state == ST_IDLE) begin
                  state_n = ST_RUN;
                  count_n = load_q;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end else if (sel_load) begin
            load_n = wdata;
`ifdef TIMER_PRESCALER_EN
         end else if (sel_prescale) begin
            prescale_n = wdata[P_PRESCALE_WIDTH-1:0];
`endif
         end
      end

      // Counting only when already running and not stopped this edge.
      // count 0 (LOAD=0 start) expires like the 1->0 transition.
      if ((state == ST_RUN) && (state_n == ST_RUN) && tick) begin
         if (count <= P_DATA_WIDTH'(1)) begin
            expired_n = 1'b1;
            if (reload_en_n) begin
               count_n = load_q;
            end else begin
               count_n = '0;
               state_n = ST_IDLE;
            end
         end else begin
            count_n = count - 1'b1;
         end
      end
   end

   // Read data reflects the values after this edge's update
   always_comb begin
      rd_next = '0;
      if (sel_control) begin
         rd_next[P_BIT_START]     = (state_n == ST_RUN);
         rd_next[P_BIT_RELOAD_EN] = reload_en_n;
      end else if (sel_load) begin
         rd_next = load_n;
      end else if (sel_status) begin
         rd_next[P_BIT_EXPIRED] = expired_n;
      end else if (sel_count) begin
         rd_next = count_n;
`ifdef TIMER_PRESCALER_EN
      end else if (sel_prescale) begin
         rd_next[P_PRESCALE_WIDTH-1:0] = prescale_n;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         reload_en <= 1'b0;
         expired   <= 1'b0;
         load_q    <= '0;
         count     <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         reload_en <= reload_en_n;
         expired   <= expired_n;
         load_q    <= load_n;
         count     <= count_n;
         rvalid    <= is_rd;
         err       <= accept && !mapped;
         if (is_rd) rdata <= rd_next;
      end
   end

`ifdef TIMER_PRESCALER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prescale <= '0;
      else     prescale <= prescale_n;
   end
`endif

endmodule

// File: tb/tb_timer_regs_core.sv
module tb_timer_regs_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        kind;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   timer_regs_core #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .kind   (kind),
      .addr   (addr),
      .wdata  (wdata),
      .ready  (ready),
      .rdata  (rdata),
      .rvalid (rvalid),
      .err    (err),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   // Bus helpers: called at a negedge, return at the following negedge.
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      req = 1'b1; kind = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d,
                     output logic v, output logic e);
      req = 1'b1; kind = 1'b1; addr = a;
      @(negedge clk);
      req = 1'b0;
      d = rdata; v = rvalid; e = err;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v, e;
      rst = 1'b1; req = 1'b0; kind = 1'b0; addr = '0; wdata = '0;
      #1;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", ready); end
      checks++; if ({rvalid, err, irq} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {rvalid, err, irq}); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
      idle(2);
      rst = 1'b0;
      idle(1);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%0h exp=1", ready); end
      // Mid-run reset with LOAD=5 and a read response in flight
      wr(8'h04, 32'd5);
      wr(8'h00, 32'h1);
      req = 1'b1; kind = 1'b1; addr = 8'h0C;
      @(posedge clk); #1;
      req = 1'b0;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'd4) begin failures++; $display("FAIL midrun_count got=%0h/%0d exp=1/4", rvalid, rdata); end
      rst = 1'b1;
      #1;
      checks++; if ({ready, rvalid, err, irq} !== 4'b0000) begin failures++; $display("FAIL midrun_reset_out got=%b exp=0000", {ready, rvalid, err, irq}); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL midrun_reset_rdata got=%0h exp=0", rdata); end
      idle(2);
      rst = 1'b0;
      rd(8'h0C, d, v, e);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL post_reset_count got=%0h/%0h exp=1/0", v, d); end
      rd(8'h00, d, v, e);
      checks++; if (d !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL post_reset_control got=%0h irq=%0h exp=0/0", d, irq); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d; logic v, e;
      wr(8'h04, 32'd4);
      wr(8'h00, 32'h1);
      idle(3);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_early_irq got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq got=%0h exp=1", irq); end
      rd(8'h0C, d, v, e);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL oneshot_count got=%0h exp=0", d); end
      rd(8'h00, d, v, e);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL oneshot_control got=%0h exp=0", d); end
      rd(8'h08, d, v, e);
      checks++; if (d !== 32'h1 || e !== 1'b0) begin failures++; $display("FAIL oneshot_status got=%0h err=%0h exp=1/0", d, e); end
   endtask

   task automatic test_load_zero();
      logic [31:0] d; logic v, e;
      wr(8'h00, 32'h4);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_status got=%0h exp=0", irq); end
      wr(8'h04, 32'd0);
      wr(8'h00, 32'h1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL load0_early got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL load0_irq got=%0h exp=1", irq); end
      rd(8'h00, d, v, e);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL load0_control got=%0h exp=0", d); end
   endtask

   task automatic test_reload();
      logic [31:0] d; logic v, e;
      wr(8'h00, 32'h4);
      wr(8'h04, 32'd3);
      wr(8'h00, 32'h3);
      idle(2);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reload_early got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL reload_first got=%0h exp=1", irq); end
      wr(8'h00, 32'h7);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reload_clr got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reload_gap got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL reload_second got=%0h exp=1", irq); end
      wr(8'h00, 32'h7);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reload_clr2 got=%0h exp=0", irq); end
      idle(1);
      // CLR_STATUS lands on the third expiry edge: set must win
      wr(8'h00, 32'h7);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL simul_irq got=%0h exp=1", irq); end
      rd(8'h08, d, v, e);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL simul_status got=%0h exp=1", d); end
      rd(8'h00, d, v, e);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL reload_control got=%0h exp=3", d); end
      wr(8'h00, 32'h0);
   endtask

   task automatic test_bus();
      logic [31:0] d; logic v, e;
      rd(8'h20, d, v, e);
      checks++; if ({v, e} !== 2'b11 || d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%b/%0h exp=11/0", {v, e}, d); end
      idle(1);
      checks++; if ({rvalid, err} !== 2'b00) begin failures++; $display("FAIL strobe_width got=%b exp=00", {rvalid, err}); end
      wr(8'h04, 32'd10);
      wr(8'h00, 32'h1);
      req = 1'b1; kind = 1'b1; addr = 8'h04;
      @(negedge clk);
      checks++; if (rvalid !== 1'b1 || rdata !== 32'd10) begin failures++; $display("FAIL b2b_load got=%0h/%0d exp=1/10", rvalid, rdata); end
      addr = 8'h0C;
      @(negedge clk);
      checks++; if (rvalid !== 1'b1 || rdata !== 32'd8) begin failures++; $display("FAIL b2b_count1 got=%0h/%0d exp=1/8", rvalid, rdata); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b1 || rdata !== 32'd7) begin failures++; $display("FAIL b2b_count2 got=%0h/%0d exp=1/7", rvalid, rdata); end
      req = 1'b0;
      @(negedge clk);
      checks++; if (rvalid !== 1'b0 || rdata !== 32'd7) begin failures++; $display("FAIL rdata_hold got=%0h/%0d exp=0/7", rvalid, rdata); end
      wr(8'h00, 32'h0);
      rd(8'h0C, d, v, e);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL halt_count got=%0d exp=6", d); end
      rd(8'h0C, d, v, e);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL halt_hold got=%0d exp=6", d); end
   endtask

   task automatic test_prescale();
      logic [31:0] d; logic v, e;
`ifdef TIMER_PRESCALER_EN
      wr(8'h10, 32'd1);
      rd(8'h10, d, v, e);
      checks++; if (d !== 32'd1 || e !== 1'b0) begin failures++; $display("FAIL prescale_rb got=%0h err=%0h exp=1/0", d, e); end
      wr(8'h00, 32'h4);
      wr(8'h04, 32'd2);
      wr(8'h00, 32'h1);
      idle(3);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL prescale_early got=%0h exp=0", irq); end
      idle(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prescale_irq got=%0h exp=1", irq); end
`else
      req = 1'b1; kind = 1'b0; addr = 8'h10; wdata = 32'd5;
      @(negedge clk);
      req = 1'b0;
      checks++; if ({err, rvalid} !== 2'b10) begin failures++; $display("FAIL unmapped_write got=%b exp=10", {err, rvalid}); end
      rd(8'h10, d, v, e);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL unmapped_0x10_read got=%0h/%0h exp=1/0", e, d); end
`endif
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_load_zero();
      test_reload();
      test_bus();
      test_prescale();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
